// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, legal
// parameter ranges and the occupancy-width helper. Honours UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_W_MIN       = 5;
    localparam int DATA_W_MAX       = 9;
    localparam int FIFO_DEPTH_MIN   = 4;
    localparam int FIFO_DEPTH_MAX   = 4096;
    localparam int CLKS_PER_BIT_MIN = 2;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;

    // Occupancy needs one bit more than the address so "full" is representable.
    function automatic int usedw_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read data, registered full/empty flags
// and occupancy count. Storage is a plain array so it maps onto block RAM.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wen,
    input  logic [DATA_W-1:0]                     wdata,
    input  logic                                  ren,
    output logic [DATA_W-1:0]                     rdata,
    output logic                                  full,
    output logic                                  empty,
    output logic [usedw_width(FIFO_DEPTH)-1:0]    usedw
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = usedw_width(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rdata_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [UW-1:0]     count_reg;
    logic [UW-1:0]     count_next;
    logic              full_reg;
    logic              empty_reg;
    logic              do_wr;
    logic              do_rd;

    // Requests against a full/empty FIFO are ignored rather than corrupting state.
    assign do_wr = wen & ~full_reg;
    assign do_rd = ren & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        if (do_wr && !do_rd) begin
            count_next = count_reg + UW'(1);
        end else if (do_rd && !do_wr) begin
            count_next = count_reg - UW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wdata;
        end
        if (do_rd) begin
            rdata_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == UW'(FIFO_DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign rdata = rdata_reg;
    assign full  = full_reg;
    assign empty = empty_reg;
    assign usedw = count_reg;

endmodule

// File: rtl/uart_tx_mc.sv
// UART transmitter: TX FIFO feeding a start/data/[parity]/stop serialiser.
// Defining UART_TX_PARITY_EN adds the tx_par_odd port and a parity bit.
module uart_tx_mc
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  ena,
`ifdef UART_TX_PARITY_EN
    input  logic                                  tx_par_odd,
`endif
    input  logic                                  tx_fifo_wen,
    input  logic [DATA_W-1:0]                     tx_fifo_wdata,
    output logic                                  tx_fifo_full,
    output logic                                  tx_fifo_empty,
    output logic [usedw_width(FIFO_DEPTH)-1:0]    tx_fifo_usedw,
    output logic                                  txd,
    output logic                                  tx_work
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
        FIFO_DEPTH < FIFO_DEPTH_MIN || FIFO_DEPTH > FIFO_DEPTH_MAX ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        CLKS_PER_BIT < CLKS_PER_BIT_MIN ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_param_check
        $error("uart_tx_mc: parameter out of legal range");
    end

    tx_state_t         state_reg;
    logic [BW-1:0]     baud_cnt_reg;
    logic [3:0]        bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              txd_reg;
    logic              tx_work_reg;
    logic [DATA_W-1:0] fifo_rdata;
    logic              bit_done;
    logic              last_stop;
    logic              pop;
`ifdef UART_TX_PARITY_EN
    logic              par_odd_reg;
    logic              parity_reg;
`endif

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wen   (tx_fifo_wen),
        .wdata (tx_fifo_wdata),
        .ren   (pop),
        .rdata (fifo_rdata),
        .full  (tx_fifo_full),
        .empty (tx_fifo_empty),
        .usedw (tx_fifo_usedw)
    );

    assign bit_done  = (baud_cnt_reg == '0);
    assign last_stop = (state_reg == ST_STOP) && bit_done && (bit_cnt_reg == STOP_LAST);
    // Popping on the final stop cycle lets the next start bit follow with no gap.
    assign pop       = ena && !tx_fifo_empty && ((state_reg == ST_IDLE) || last_stop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
            tx_work_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_odd_reg  <= 1'b0;
            parity_reg   <= 1'b0;
`endif
        end else begin
            if (state_reg != ST_IDLE) begin
                baud_cnt_reg <= bit_done ? BAUD_LAST : baud_cnt_reg - BW'(1);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        state_reg    <= ST_START;
                        txd_reg      <= 1'b0;
                        tx_work_reg  <= 1'b1;
                        baud_cnt_reg <= BAUD_LAST;
`ifdef UART_TX_PARITY_EN
                        par_odd_reg  <= tx_par_odd;
`endif
                    end
                end
                ST_START: begin
                    // Popped word is valid in the FIFO read register by now.
                    if (bit_done) begin
                        state_reg   <= ST_DATA;
                        txd_reg     <= fifo_rdata[0];
                        shift_reg   <= {1'b0, fifo_rdata[DATA_W-1:1]};
                        bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_reg  <= (^fifo_rdata) ^ par_odd_reg;
`endif
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                            state_reg   <= ST_PARITY;
                            txd_reg     <= parity_reg;
`else
                            state_reg   <= ST_STOP;
                            txd_reg     <= 1'b1;
`endif
                        end else begin
                            txd_reg     <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[DATA_W-1:1]};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        state_reg   <= ST_STOP;
                        txd_reg     <= 1'b1;
                        bit_cnt_reg <= '0;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_reg <= '0;
                            if (pop) begin
                                state_reg <= ST_START;
                                txd_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                                par_odd_reg <= tx_par_odd;
`endif
                            end else begin
                                state_reg   <= ST_IDLE;
                                txd_reg     <= 1'b1;
                                tx_work_reg <= 1'b0;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    txd_reg     <= 1'b1;
                    tx_work_reg <= 1'b0;
                end
            endcase
        end
    end

    assign txd     = txd_reg;
    assign tx_work = tx_work_reg;

endmodule

// File: tb/tb_uart_tx_mc.sv
// Directed bench for uart_tx_mc (CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1, FIFO_DEPTH=4);
// the parity case is exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_mc;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CPB  = 4;
    localparam int FB   = 1 + 8 + P + 1;
    localparam int FC   = FB * CPB;
    localparam int MAXV = 4 * FC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       tx_par_odd = 1'b0;
    logic       tx_fifo_wen = 1'b0;
    logic [7:0] tx_fifo_wdata = '0;
    logic       tx_fifo_full;
    logic       tx_fifo_empty;
    logic [2:0] tx_fifo_usedw;
    logic       txd;
    logic       tx_work;

    logic [MAXV-1:0] txd_v;
    logic [MAXV-1:0] work_v;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_mc #(
        .DATA_W       (8),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
`ifdef UART_TX_PARITY_EN
        .tx_par_odd    (tx_par_odd),
`endif
        .tx_fifo_wen   (tx_fifo_wen),
        .tx_fifo_wdata (tx_fifo_wdata),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_usedw (tx_fifo_usedw),
        .txd           (txd),
        .tx_work       (tx_work)
    );

    task automatic chk(input string tag, input logic [MAXV-1:0] obs, input logic [MAXV-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h", tag, obs);
    endtask

    // Expected line waveform of one frame, one bit per clock cycle, LSB = first cycle.
    function automatic logic [MAXV-1:0] frame_bits(input logic [7:0] d, input logic odd);
        logic [MAXV-1:0] r;
        logic bv;
        r = '0;
        for (int b = 0; b < FB; b++) begin
            if (b == 0)                bv = 1'b0;
            else if (b <= 8)           bv = d[b-1];
            else if (P == 1 && b == 9) bv = (^d) ^ odd;
            else                       bv = 1'b1;
            for (int k = 0; k < CPB; k++) r[b*CPB+k] = bv;
        end
        return r;
    endfunction

    function automatic logic [MAXV-1:0] frames(input logic [31:0] words, input int n, input logic odd);
        logic [MAXV-1:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r = r | (frame_bits(words[8*k +: 8], odd) << (k*FC));
        return r;
    endfunction

    function automatic logic [MAXV-1:0] ones(input int n);
        logic [MAXV-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic write_word(input logic [7:0] d);
        tx_fifo_wen   = 1'b1;
        tx_fifo_wdata = d;
        @(posedge clk); #1;
        tx_fifo_wen   = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk); #1;
            if (tx_work) found = 1'b1;
        end
        chk(tag, MAXV'(found), MAXV'(1));
    endtask

    // Sample n consecutive cycles, starting with the current one.
    task automatic capture(input int n, input int drop_at, input int wen_off);
        txd_v  = '0;
        work_v = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            txd_v[i]  = txd;
            work_v[i] = tx_work;
            if (i == drop_at) ena = 1'b0;
            if (i == wen_off) tx_fifo_wen = 1'b0;
        end
    endtask

    initial begin
        int busy;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txd",   MAXV'(txd), MAXV'(1));
        chk("rst_work",  MAXV'(tx_work), MAXV'(0));
        chk("rst_empty", MAXV'(tx_fifo_empty), MAXV'(1));
        chk("rst_full",  MAXV'(tx_fifo_full), MAXV'(0));
        chk("rst_usedw", MAXV'(tx_fifo_usedw), MAXV'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Single frame 0xA5
        ena = 1'b1;
        write_word(8'hA5);
        chk("a5_usedw1", MAXV'(tx_fifo_usedw), MAXV'(1));
        chk("a5_empty0", MAXV'(tx_fifo_empty), MAXV'(0));
        wait_start("a5_start", 5);
        capture(FC, -1, -1);
        chk("a5_txd",  txd_v, frames(32'hA5, 1, 1'b0));
        chk("a5_work", work_v, ones(FC));
        @(posedge clk); #1;
        chk("a5_end_work",  MAXV'(tx_work), MAXV'(0));
        chk("a5_end_usedw", MAXV'(tx_fifo_usedw), MAXV'(0));

        // Three back-to-back frames
        write_word(8'h01);
        tx_fifo_wen = 1'b1;
        tx_fifo_wdata = 8'h02;
        wait_start("b2b_start", 5);
        tx_fifo_wdata = 8'h03;
        capture(3*FC, -1, 1);
        chk("b2b_txd",  txd_v, frames(32'h030201, 3, 1'b0));
        chk("b2b_work", work_v, ones(3*FC));
        @(posedge clk); #1;
        chk("b2b_end_work",  MAXV'(tx_work), MAXV'(0));
        chk("b2b_end_txd",   MAXV'(txd), MAXV'(1));
        chk("b2b_end_usedw", MAXV'(tx_fifo_usedw), MAXV'(0));

        // Fill with ena low, fifth write dropped
        ena = 1'b0;
        write_word(8'h10);
        write_word(8'h11);
        write_word(8'h12);
        write_word(8'h13);
        write_word(8'h14);
        chk("fill_full",  MAXV'(tx_fifo_full), MAXV'(1));
        chk("fill_usedw", MAXV'(tx_fifo_usedw), MAXV'(4));
        chk("fill_work",  MAXV'(tx_work), MAXV'(0));
        ena = 1'b1;
        wait_start("fill_start", 5);
        capture(4*FC, -1, -1);
        chk("fill_txd",  txd_v, frames(32'h13121110, 4, 1'b0));
        chk("fill_work_v", work_v, ones(4*FC));
        @(posedge clk); #1;
        chk("fill_end_work",  MAXV'(tx_work), MAXV'(0));
        chk("fill_end_empty", MAXV'(tx_fifo_empty), MAXV'(1));

        // Reset in the middle of a frame with a second word queued
        write_word(8'h5A);
        tx_fifo_wen = 1'b1;
        tx_fifo_wdata = 8'h77;
        wait_start("rst_mid_start", 5);
        capture(11, -1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_txd",   MAXV'(txd), MAXV'(1));
        chk("rst_mid_work",  MAXV'(tx_work), MAXV'(0));
        chk("rst_mid_usedw", MAXV'(tx_fifo_usedw), MAXV'(0));
        chk("rst_mid_empty", MAXV'(tx_fifo_empty), MAXV'(1));
        busy = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (tx_work || !txd) busy++;
        end
        chk("rst_mid_quiet", MAXV'(busy), MAXV'(0));

        // Drop ena during frame 1 of 2
        write_word(8'h3C);
        tx_fifo_wen = 1'b1;
        tx_fifo_wdata = 8'hC3;
        wait_start("ena_start", 5);
        capture(FC, 12, 0);
        chk("ena_f1_txd", txd_v, frames(32'h3C, 1, 1'b0));
        @(posedge clk); #1;
        chk("ena_f1_work",  MAXV'(tx_work), MAXV'(0));
        chk("ena_f1_usedw", MAXV'(tx_fifo_usedw), MAXV'(1));
        repeat (20) @(posedge clk);
        #1;
        chk("ena_hold_work",  MAXV'(tx_work), MAXV'(0));
        chk("ena_hold_usedw", MAXV'(tx_fifo_usedw), MAXV'(1));
        ena = 1'b1;
        wait_start("ena_f2_start", 5);
        capture(FC, -1, -1);
        chk("ena_f2_txd",   txd_v, frames(32'hC3, 1, 1'b0));
        chk("ena_f2_usedw", MAXV'(tx_fifo_usedw), MAXV'(0));
        @(posedge clk); #1;

`ifdef UART_TX_PARITY_EN
        // Odd parity over 0x03
        tx_par_odd = 1'b1;
        write_word(8'h03);
        tx_par_odd = 1'b0;
        wait_start("par_start", 5);
        capture(FC, -1, -1);
        chk("par_txd",  txd_v, frames(32'h03, 1, 1'b1));
        chk("par_bit",  MAXV'(txd_v[9*CPB+1]), MAXV'(1));
        chk("par_work", work_v, ones(44));
        @(posedge clk); #1;
        chk("par_end_work", MAXV'(tx_work), MAXV'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_mc.md
UART_TX_MC -- requirements
Module: uart_tx_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the TX FIFO depth (power of 2, 4..4096).
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per bit (legal >= 2).
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame (legal 1 or 2).
REQ-005 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ena  input  1  transmit enable; gates the start of new frames only.
REQ-008 tx_fifo_wen  input  1  FIFO write request.
REQ-009 tx_fifo_wdata  input  DATA_W  FIFO write data.
REQ-010 tx_fifo_full  output  1  FIFO full.
REQ-011 tx_fifo_empty  output  1  FIFO empty.
REQ-012 tx_fifo_usedw  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 txd  output  1  serial line, idle high.
REQ-014 tx_work  output  1  high while a frame is on the line.

Function
REQ-015 A write SHALL be accepted iff tx_fifo_wen=1 and tx_fifo_full=0; writes while full SHALL be dropped, with no state change.
REQ-016 The FIFO flags and usedw SHALL be registered and SHALL reflect all accepted writes and pops by the next cycle.
REQ-017 A simultaneous accepted write and pop SHALL leave usedw unchanged.
REQ-018 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: when ena=1 and tx_fifo_empty=0, the block SHALL pop one word and enter START on the next cycle, driving txd=0 from that cycle.
REQ-021 Each state SHALL hold its bit for exactly CLKS_PER_BIT cycles, using a baud counter that reloads at every bit boundary.
REQ-022 DATA SHALL send DATA_W bits LSB first.
REQ-023 After DATA, the FSM SHALL go to PARITY (macro defined) or to STOP.
REQ-024 STOP SHALL drive txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-025 On the last STOP cycle, if ena=1 and the FIFO is not empty, the block SHALL pop and go directly to START, giving back-to-back frames with no idle gap; otherwise it SHALL go to IDLE.
REQ-026 Deasserting ena mid-frame SHALL NOT truncate the current frame; no further pop SHALL occur.
REQ-027 tx_work SHALL be 1 in every state except IDLE.
REQ-028 txd SHALL be driven from a register (glitch-free).
REQ-029 Frame length SHALL be (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 if parity is compiled in and 0 otherwise.

Reset
REQ-030 While rst=1, the block SHALL set: state=IDLE, txd=1, tx_work=0, tx_fifo_empty=1, tx_fifo_full=0, tx_fifo_usedw=0, FIFO contents discarded, baud and bit counters cleared.
REQ-031 rst asserted mid-frame SHALL abort the frame; txd SHALL be 1 from the first edge with rst=1.

Configuration
REQ-032 When UART_TX_PARITY_EN is defined, the block SHALL add input port tx_par_odd (1 bit; 0 = even, 1 = odd parity) and insert one parity bit over the DATA_W bits, sampled at the pop.
REQ-033 When UART_TX_PARITY_EN is undefined, the PARITY state and the tx_par_odd port SHALL be absent.

Structure
REQ-034 The state encoding, the legal parameter ranges and a usedw-width function SHALL be placed in the shared package uart_pkg.
REQ-035 The FIFO SHALL be a separate sub-module, uart_sync_fifo (single-clock, parametrised DATA_W/FIFO_DEPTH); the FSM and shifter SHALL live in uart_tx_mc.

Verification (CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1, FIFO_DEPTH=4 unless noted)
REQ-036 Write 0xA5 with ena=1 -> txd holds 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; tx_work=1 for 40 cycles; usedw returns to 0.
REQ-037 Write 0x01,0x02,0x03 back-to-back with ena=1 -> three contiguous frames, 120 cycles total, with no idle cycle between stop and start; tx_work high throughout.
REQ-038 ena=0, write 5 words -> 4 accepted, full=1, usedw=4, 5th dropped; then ena=1 -> exactly the 4 accepted words are sent, in order.
REQ-039 Assert rst for 1 cycle at cycle 10 of a frame -> txd=1, tx_work=0, usedw=0, empty=1 on the next cycle; nothing is sent afterwards.
REQ-040 Drop ena in the middle of frame 1 of 2 queued -> frame 1 completes, frame 2 stays queued (usedw=1) until ena returns.
REQ-041 With UART_TX_PARITY_EN defined and tx_par_odd=1, send 0x03 -> the parity bit is 1; the frame is 44 cycles long.
